// File: rtl/aes_mode_seq.sv
// aes_mode_seq: sequencer in front of one aes_core. Takes a key/IV config and a
// stream of 128-bit blocks, drives init/next, waits on core_ready, returns results.
// Latency: in handshake -> out_valid = 2 cycles + core processing time.
// Backpressure: out_valid/out_data/out_last hold until out_ready; no new block or
// core_next is issued while a result is pending.
// Optional CBC chaining: compile with AES_MODE_CBC_EN defined; otherwise ECB only.
// Ports: clk/reset_n; cfg_* config stream; in_* block stream; out_* result stream;
// busy/err status; core_* pins to/from aes_core.
module aes_mode_seq #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic         cfg_encdec,
  input  logic         cfg_keylen,
  input  logic [255:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         err,
  output logic         core_encdec,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic         core_keylen,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  input  logic         core_result_valid
);

  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_KINIT, S_KWAIT, S_LOAD, S_BSTART, S_BWAIT, S_OUT
  } state_t;

  state_t       state, state_n;
  logic         alive;       // keeps cfg_ready low while reset is asserted
  logic [7:0]   wcnt;
  logic         last_r;
  logic         wait_done;
  logic         wd_fire;
  logic         cfg_fire, in_fire, res_fire;
  logic [127:0] blk_in;
  logic [127:0] res_out;

  // The core's ready from before the init/next pulse is stale, so the first
  // wait cycle (wcnt == 0) never counts as completion.
  assign wait_done = core_ready && (wcnt != 8'd0);

  assign cfg_fire = (state == S_IDLE) && alive && cfg_valid;
  assign in_fire  = (state == S_LOAD) && in_valid;
  assign res_fire = (state == S_BWAIT) && wait_done;

  assign cfg_ready = alive && (state == S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);
  assign core_init = (state == S_KINIT);
  assign core_next = (state == S_BSTART);

  always_comb begin
    state_n = state;
    wd_fire = 1'b0;
    case (state)
      S_IDLE:   if (cfg_fire) state_n = S_KINIT;
      S_KINIT:  state_n = S_KWAIT;
      S_KWAIT: begin
        if (wait_done) begin
          state_n = S_LOAD;
        end else if (wcnt == WAIT_MAX) begin
          state_n = S_IDLE;
          wd_fire = 1'b1;
        end
      end
      S_LOAD:   if (in_valid) state_n = S_BSTART;
      S_BSTART: state_n = S_BWAIT;
      S_BWAIT: begin
        if (wait_done) begin
          state_n = S_OUT;
        end else if (wcnt == WAIT_MAX) begin
          state_n = S_IDLE;
          wd_fire = 1'b1;
        end
      end
      S_OUT:    if (out_ready) state_n = last_r ? S_IDLE : S_LOAD;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_n;
      alive <= 1'b1;
    end
  end

  // Watchdog counter: cleared by the pulse state that precedes each wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= 8'd0;
      err  <= 1'b0;
    end else begin
      if (state == S_KINIT || state == S_BSTART) begin
        wcnt <= 8'd0;
      end else if (state == S_KWAIT || state == S_BWAIT) begin
        wcnt <= wcnt + 8'd1;
      end
      if (wd_fire) err <= 1'b1;
    end
  end

`ifdef AES_MODE_CBC_EN
  logic [127:0] chain;
  logic [127:0] cbuf;   // ciphertext of the block in flight, next chain value on decrypt

  assign blk_in  = core_encdec ? (in_data ^ chain) : in_data;
  assign res_out = core_encdec ? core_result : (core_result ^ chain);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      cbuf  <= '0;
    end else begin
      if (cfg_fire) chain <= cfg_iv;
      if (in_fire)  cbuf  <= in_data;
      if (res_fire) chain <= core_encdec ? core_result : cbuf;
    end
  end
`else
  logic unused_iv;

  assign unused_iv = ^cfg_iv;
  assign blk_in    = in_data;
  assign res_out   = core_result;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_key    <= '0;
      core_keylen <= 1'b0;
      core_encdec <= 1'b0;
      core_block  <= '0;
      last_r      <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      if (cfg_fire) begin
        core_key    <= cfg_key;
        core_keylen <= cfg_keylen;
        core_encdec <= cfg_encdec;
      end
      if (in_fire) begin
        core_block <= blk_in;
        last_r     <= in_last;
      end
      if (res_fire) begin
        out_data <= res_out;
        out_last <= last_r;
      end
    end
  end

  a_pulse_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(core_init && core_next));
  a_result_valid: assert property (@(posedge clk) disable iff (!reset_n)
    res_fire |-> core_result_valid);

endmodule

// File: tb/tb_aes_mode_seq.sv
module tb_aes_mode_seq;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_valid, cfg_ready, cfg_encdec, cfg_keylen;
  logic [255:0] cfg_key;
  logic [127:0] cfg_iv;
  logic         in_valid, in_ready, in_last;
  logic [127:0] in_data;
  logic         out_valid, out_ready, out_last;
  logic [127:0] out_data;
  logic         busy, err;
  logic         core_encdec, core_init, core_next, core_keylen;
  logic [255:0] core_key;
  logic [127:0] core_block;

  // stub core state
  logic [7:0]   stub_lat   = 8'd5;
  logic         stub_stall = 1'b0;
  logic [7:0]   stub_cnt   = 8'd0;
  logic         stub_rdy   = 1'b1;
  logic         stub_rv    = 1'b0;
  logic         stub_blk   = 1'b0;
  logic [127:0] stub_res   = '0;

  int n_chk = 0;
  int n_fail = 0;
  int next_cnt = 0;
  int overlap = 0;
  int ov_cycles = 0;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  // AES-128(K1) pairs: ECB of P1/P2, and of the CBC-chained inputs
  localparam logic [127:0] X1 = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] X2 = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] EC1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] EC2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] CB1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CB2 = 128'h5086cb9b507219ee95db113a917678b2;

`ifdef AES_MODE_CBC_EN
  localparam logic [127:0] C1 = CB1;
  localparam logic [127:0] C2 = CB2;
`else
  localparam logic [127:0] C1 = EC1;
  localparam logic [127:0] C2 = EC2;
`endif

  aes_mode_seq #(.WAIT_LIMIT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_encdec(cfg_encdec),
    .cfg_keylen(cfg_keylen), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err),
    .core_encdec(core_encdec), .core_init(core_init), .core_next(core_next),
    .core_key(core_key), .core_keylen(core_keylen), .core_block(core_block),
    .core_ready(stub_rdy), .core_result(stub_res), .core_result_valid(stub_rv)
  );

  always #5 clk = ~clk;

  // Table-driven stand-in for aes_core: known AES vectors only.
  function automatic logic [127:0] aes_stub(input logic enc, input logic [255:0] key,
                                           input logic [127:0] blk);
    logic [127:0] k;
    k = key[255:128];
    aes_stub = blk ^ k;
    if (k == K0 && enc && blk == P0) aes_stub = E0;
    if (k == K1) begin
      if (enc) begin
        if (blk == P1) aes_stub = EC1;
        if (blk == P2) aes_stub = EC2;
        if (blk == X1) aes_stub = CB1;
        if (blk == X2) aes_stub = CB2;
      end else begin
        if (blk == EC1) aes_stub = P1;
        if (blk == EC2) aes_stub = P2;
        if (blk == CB1) aes_stub = X1;
        if (blk == CB2) aes_stub = X2;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (core_init) begin
      stub_rdy <= 1'b0; stub_rv <= 1'b0; stub_blk <= 1'b0; stub_cnt <= stub_lat;
    end else if (core_next) begin
      stub_rdy <= 1'b0; stub_rv <= 1'b0; stub_blk <= 1'b1; stub_cnt <= stub_lat;
      stub_res <= aes_stub(core_encdec, core_key, core_block);
    end else if (!stub_stall) begin
      if (stub_cnt != 8'd0) begin
        stub_cnt <= stub_cnt - 8'd1;
      end else if (!stub_rdy) begin
        stub_rdy <= 1'b1;
        stub_rv  <= stub_blk;
      end
    end
  end

  always @(negedge clk) begin
    if (core_next) next_cnt++;
    if (core_init && core_next) overlap++;
    if (out_valid) ov_cycles++;
  end

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send_cfg(input logic enc, input logic [127:0] key, input logic [127:0] iv);
    int n = 0;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_encdec = enc; cfg_keylen = 1'b0;
    cfg_key = {key, 128'h0}; cfg_iv = iv;
    while (!cfg_ready && n < 100) begin @(negedge clk); n++; end
    chk("cfg_hs", cfg_ready, 1);
    @(posedge clk); #1 cfg_valid = 1'b0;
  endtask

  task automatic send_in(input logic [127:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_hs", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic recv_out(output logic [127:0] res, output logic rl);
    int n = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("out_hs", out_valid, 1);
    res = out_data; rl = out_last;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [127:0] res, hold;
    logic         rl;
    int           n, n1, ov0;

    reset_n = 1'b0; cfg_valid = 1'b0; cfg_encdec = 1'b0; cfg_keylen = 1'b0;
    cfg_key = '0; cfg_iv = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_core_pulses", {core_init, core_next}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_cfg_ready", cfg_ready, 1);

    // ECB vector, single last block
    send_cfg(1'b1, K0, '0);
    send_in(P0, 1'b1);
    recv_out(res, rl);
    chk("ecb_data", res, E0);
    chk("ecb_last", rl, 1);
    @(negedge clk);
    chk("ecb_idle_busy", busy, 0);
    chk("ecb_idle_cfg_ready", cfg_ready, 1);

    // Two-block encrypt, first result held under backpressure
    send_cfg(1'b1, K1, IV);
    send_in(P1, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_reach_out", out_valid, 1);
    n1 = next_cnt;
    hold = out_data;
    chk("enc_c1", hold, C1);
    chk("enc_c1_last", out_last, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, hold);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_no_next", next_cnt, n1);
    recv_out(res, rl);
    chk("bp_data_taken", res, C1);
    send_in(P2, 1'b1);
    recv_out(res, rl);
    chk("enc_c2", res, C2);
    chk("enc_c2_last", rl, 1);

    // Decrypt the ciphertexts back
    send_cfg(1'b0, K1, IV);
    send_in(C1, 1'b0);
    recv_out(res, rl);
    chk("dec_p1", res, P1);
    chk("dec_p1_last", rl, 0);
    send_in(C2, 1'b1);
    recv_out(res, rl);
    chk("dec_p2", res, P2);
    chk("dec_p2_last", rl, 1);

    // Watchdog: core never becomes ready after init
    stub_stall = 1'b1;
    ov0 = ov_cycles;
    send_cfg(1'b1, K0, '0);
    repeat (10) @(negedge clk);
    chk("wd_err_early", err, 0);
    chk("wd_busy_early", busy, 1);
    n = 0;
    while (!err && n < 40) begin @(negedge clk); n++; end
    chk("wd_err", err, 1);
    chk("wd_cycles_min", (n >= 5), 1);
    @(negedge clk);
    chk("wd_idle_busy", busy, 0);
    chk("wd_cfg_ready", cfg_ready, 1);
    chk("wd_no_output", ov_cycles, ov0);
    stub_stall = 1'b0;

    // err is sticky across a normal message
    send_cfg(1'b1, K0, '0);
    send_in(P0, 1'b1);
    recv_out(res, rl);
    chk("wd_after_data", res, E0);
    chk("wd_err_sticky", err, 1);

    // Reset during BWAIT
    stub_lat = 8'd12;
    send_cfg(1'b1, K0, '0);
    send_in(P0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("rbw_busy", busy, 1);
    chk("rbw_next_seen", core_next, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("rbw_busy0", busy, 0);
    chk("rbw_cfg_ready0", cfg_ready, 0);
    chk("rbw_out_valid0", out_valid, 0);
    chk("rbw_in_ready0", in_ready, 0);
    chk("rbw_err0", err, 0);
    chk("rbw_block0", core_block, 0);
    chk("rbw_key0", core_key, 0);
    chk("rbw_out_data0", out_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ov0 = ov_cycles;
    out_ready = 1'b1;
    repeat (25) @(negedge clk);
    out_ready = 1'b0;
    chk("rbw_no_output", ov_cycles, ov0);
    stub_lat = 8'd5;
    send_cfg(1'b1, K0, '0);
    send_in(P0, 1'b1);
    recv_out(res, rl);
    chk("rbw_after_data", res, E0);
    chk("rbw_after_last", rl, 1);
    chk("rbw_after_err", err, 0);

    chk("no_init_next_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
